// File: rtl/vram_arbiter.sv
// Single-port text-RAM arbiter: GPU fetches win by default, the CPU is
// guaranteed a slot after MAX_WAIT denied cycles; each access is grant + done.
module vram_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4,
  parameter int WW       = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ready,
  input  logic          gpu_req,
  input  logic [AW-1:0] gpu_a,
  output logic [DW-1:0] gpu_q,
  output logic          gpu_ack,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_w,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    G_GPU = 3'd1,
    D_GPU = 3'd2,
    G_CPU = 3'd3,
    D_CPU = 3'd4
  } state_t;

  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);

  state_t        state_r, state_s;
  logic [WW-1:0] wait_cnt_r, wait_cnt_s;
  logic          cpu_cand_s, gpu_cand_s;
  logic [AW-1:0] mem_a_r;
  logic [DW-1:0] mem_d_r;
  logic          mem_w_r;
  logic          cpu_we_r;
  logic [DW-1:0] cpu_q_r, gpu_q_r;
  logic          cpu_ready_r, gpu_ack_r;

  // Next-state arbitration; a requester in its own done cycle is not a candidate
  always_comb begin
    state_s    = IDLE;
    cpu_cand_s = cpu_req && (state_r != D_CPU);
    gpu_cand_s = gpu_req && (state_r != D_GPU);
    case (state_r)
      G_GPU: state_s = D_GPU;
      G_CPU: state_s = D_CPU;
      IDLE, D_GPU, D_CPU: begin
        if (cpu_cand_s && (wait_cnt_r >= WAIT_LIMIT)) begin
          state_s = G_CPU;
        end else if (gpu_cand_s) begin
          state_s = G_GPU;
        end else if (cpu_cand_s) begin
          state_s = G_CPU;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // CPU starvation counter: counts denied cycles, saturating at the limit
  always_comb begin
    wait_cnt_s = wait_cnt_r;
    if (state_s == G_CPU) begin
      wait_cnt_s = {WW{1'b0}};
    end else if (!cpu_req) begin
      wait_cnt_s = {WW{1'b0}};
    end else if ((state_r != G_CPU) && (state_r != D_CPU) && (wait_cnt_r < WAIT_LIMIT)) begin
      wait_cnt_s = wait_cnt_r + WAIT_ONE;
    end else begin
      wait_cnt_s = wait_cnt_r;
    end
  end

  // State, completion strobes and RAM command registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      wait_cnt_r  <= {WW{1'b0}};
      cpu_ready_r <= 1'b0;
      gpu_ack_r   <= 1'b0;
      mem_a_r     <= {AW{1'b0}};
      mem_d_r     <= {DW{1'b0}};
      mem_w_r     <= 1'b0;
      cpu_we_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      cpu_ready_r <= (state_s == D_CPU);
      gpu_ack_r   <= (state_s == D_GPU);
      if (state_s == G_GPU) begin
        mem_a_r <= gpu_a;
        mem_w_r <= 1'b0;
      end else if (state_s == G_CPU) begin
        mem_a_r  <= cpu_a;
        mem_d_r  <= cpu_d;
        mem_w_r  <= cpu_we;
        cpu_we_r <= cpu_we;
      end else begin
        mem_w_r <= 1'b0;
      end
    end
  end

  // Read-data hold registers, loaded in the done cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_q_r <= {DW{1'b0}};
      gpu_q_r <= {DW{1'b0}};
    end else begin
      if (state_r == D_GPU) begin
        gpu_q_r <= mem_q;
      end
      if ((state_r == D_CPU) && !cpu_we_r) begin
        cpu_q_r <= mem_q;
      end
    end
  end

  // RAM data arrives in the done cycle, so it is forwarded while the strobe is high
  assign cpu_q     = (cpu_ready_r && !cpu_we_r) ? mem_q : cpu_q_r;
  assign gpu_q     = gpu_ack_r ? mem_q : gpu_q_r;
  assign cpu_ready = cpu_ready_r;
  assign gpu_ack   = gpu_ack_r;
  assign mem_a     = mem_a_r;
  assign mem_d     = mem_d_r;
  assign mem_w     = mem_w_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_vram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_a = 12'h000;
  logic [DW-1:0] cpu_d = 8'h00;
  logic          gpu_req = 1'b0;
  logic [AW-1:0] gpu_a = 12'h000;
  logic [DW-1:0] cpu_q, gpu_q, mem_d, mem_q;
  logic          cpu_ready, gpu_ack, mem_w;
  logic [AW-1:0] mem_a;

  logic [DW-1:0] ram [0:4095];
  logic          init_req = 1'b0, ld_en = 1'b0;
  logic [AW-1:0] ld_a = 12'h000;
  logic [DW-1:0] ld_d = 8'h00;

  int checks = 0;
  int failures = 0;

  // reference model state: owner 0 none / 1 gpu / 2 cpu, phase 1 grant / 2 done
  logic [DW-1:0] mem_ref [0:4095];
  int            m_who, m_ph, m_wait;
  logic [AW-1:0] m_ca, m_ga, e_ma;
  logic [DW-1:0] m_cd, e_md, e_cq, e_gq;
  logic          m_cwe;

  typedef struct packed {
    logic          creq;
    logic          cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          greq;
    logic [AW-1:0] ga;
    logic          rdy;
    logic          ack;
    logic          mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] cq;
    logic [DW-1:0] gq;
  } vec_t;
  vec_t vecs [14];

  always #20 clock = ~clock;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .WW(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_ready(cpu_ready),
    .gpu_req(gpu_req), .gpu_a(gpu_a), .gpu_q(gpu_q), .gpu_ack(gpu_ack),
    .mem_a(mem_a), .mem_d(mem_d), .mem_w(mem_w), .mem_q(mem_q)
  );

  function automatic logic [7:0] fill(input logic [11:0] a);
    logic [15:0] t;
    t = {4'h0, a} * 16'd37 + 16'd11;
    return t[7:0];
  endfunction

  // single-port synchronous RAM with one-cycle read latency
  always @(posedge clock) begin
    if (init_req) begin
      for (int i = 0; i < 4096; i++) ram[i] <= fill(12'(i));
    end else if (ld_en) begin
      ram[ld_a] <= ld_d;
    end else if (mem_w) begin
      ram[mem_a] <= mem_d;
    end
    mem_q <= ram[mem_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic model_reset();
    m_who = 0; m_ph = 0; m_wait = 0;
    m_ca = 12'h000; m_ga = 12'h000; e_ma = 12'h000;
    m_cd = 8'h00; e_md = 8'h00; e_cq = 8'h00; e_gq = 8'h00; m_cwe = 1'b0;
    for (int i = 0; i < 4096; i++) mem_ref[i] = fill(12'(i));
  endtask

  // advance the model across one clock edge using the inputs now applied
  task automatic model_step();
    int  nwho, nph;
    bit  cpu_c, gpu_c;
    cpu_c = cpu_req && !(m_who == 2 && m_ph == 2);
    gpu_c = gpu_req && !(m_who == 1 && m_ph == 2);
    if (m_ph == 1) begin
      nwho = m_who; nph = 2;
    end else begin
      nph = 1;
      if (cpu_c && m_wait >= 4) nwho = 2;
      else if (gpu_c) nwho = 1;
      else if (cpu_c) nwho = 2;
      else begin nwho = 0; nph = 0; end
    end
    if (nwho == 2 && nph == 1) m_wait = 0;
    else if (!cpu_req) m_wait = 0;
    else if (m_who != 2 && m_wait < 4) m_wait++;
    if (m_who == 2 && m_ph == 1 && m_cwe) mem_ref[m_ca] = m_cd;
    if (nwho == 2 && nph == 1) begin
      m_ca = cpu_a; m_cd = cpu_d; m_cwe = cpu_we; e_ma = cpu_a; e_md = cpu_d;
    end
    if (nwho == 1 && nph == 1) begin m_ga = gpu_a; e_ma = gpu_a; end
    if (nwho == 2 && nph == 2 && !m_cwe) e_cq = mem_ref[m_ca];
    if (nwho == 1 && nph == 2) e_gq = mem_ref[m_ga];
    m_who = nwho; m_ph = nph;
  endtask

  initial begin
    int nr, nw, rk, last, nack, t_rdy, t_ack;
    logic [AW-1:0] ga_exp;
    bit cpu_pend, gpu_pend;

    vecs[0]  = '{1'b1, 1'b1, 12'h123, 8'h5A, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h123, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 12'h123, 8'h5A, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h123, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h123, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h123, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 12'h123, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h123, 8'h5A, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h123, 8'h5A, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h7FF, 1'b0, 1'b0, 1'b0, 12'h7FF, 8'h5A, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b1, 12'h7FF, 1'b0, 1'b1, 1'b0, 12'h7FF, 8'h5A, 8'h41};
    vecs[8]  = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h7FF, 8'h5A, 8'h41};
    vecs[9]  = '{1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 12'h020, 8'h5A, 8'h41};
    vecs[10] = '{1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 12'h020, 1'b0, 1'b1, 1'b0, 12'h020, 8'h5A, 8'h77};
    vecs[11] = '{1'b1, 1'b0, 12'h010, 8'h00, 1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 12'h010, 8'h5A, 8'h77};
    vecs[12] = '{1'b1, 1'b0, 12'h010, 8'h00, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h010, 8'h33, 8'h77};
    vecs[13] = '{1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h010, 8'h33, 8'h77};

    // reset and memory preload
    @(negedge clock);
    init_req = 1'b1;
    @(negedge clock);
    init_req = 1'b0;
    load(12'h7FF, 8'h41);
    load(12'h010, 8'h33);
    load(12'h020, 8'h77);
    chk("rst_mem_a", mem_a, 12'h000);
    chk("rst_mem_d", mem_d, 8'h00);
    chk("rst_mem_w", mem_w, 1'b0);
    chk("rst_cpu_q", cpu_q, 8'h00);
    chk("rst_gpu_q", gpu_q, 8'h00);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_gpu_ack", gpu_ack, 1'b0);
    reset_n = 1'b1;

    // directed vectors: inputs for one cycle, outputs seen in the following cycle
    for (int i = 0; i < 14; i++) begin
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_a = vecs[i].ca; cpu_d = vecs[i].cd;
      gpu_req = vecs[i].greq; gpu_a = vecs[i].ga;
      @(negedge clock);
      chk($sformatf("vec%0d_ready", i), cpu_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_ack", i), gpu_ack, vecs[i].ack);
      chk($sformatf("vec%0d_mem_w", i), mem_w, vecs[i].mw);
      chk($sformatf("vec%0d_mem_a", i), mem_a, vecs[i].ma);
      chk($sformatf("vec%0d_cpu_q", i), cpu_q, vecs[i].cq);
      chk($sformatf("vec%0d_gpu_q", i), gpu_q, vecs[i].gq);
    end

    // reset in the middle of a CPU write grant
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'h200; cpu_d = 8'hC3;
    @(negedge clock);
    chk("rstmid_pre_mem_w", mem_w, 1'b1);
    #5 reset_n = 1'b0;
    #1;
    chk("rstmid_mem_w_drop", mem_w, 1'b0);
    chk("rstmid_no_ready", cpu_ready, 1'b0);
    @(negedge clock);
    chk("rstmid_ram_untouched", ram[12'h200], fill(12'h200));
    reset_n = 1'b1;
    nr = 0; nw = 0; rk = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (mem_w) nw++;
      if (cpu_ready) begin
        nr++;
        if (rk < 0) rk = k;
        cpu_req = 1'b0;
      end
    end
    chk("rstmid_ready_count", nr, 1);
    chk("rstmid_write_count", nw, 1);
    chk("rstmid_ready_cycle", rk, 1);
    chk("rstmid_ram_written", ram[12'h200], 8'hC3);

    // GPU streaming with address advancing on each ack
    gpu_req = 1'b1; gpu_a = 12'h300; ga_exp = 12'h300; last = -1; nack = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      chk("stream_mem_w", mem_w, 1'b0);
      if (gpu_ack) begin
        chk("stream_gpu_q", gpu_q, fill(ga_exp));
        if (last >= 0) chk("stream_gap", k - last, 3);
        last = k;
        ga_exp = ga_exp + 12'd1;
        gpu_a = gpu_a + 12'd1;
        nack++;
      end
    end
    chk("stream_ack_count", nack, 10);
    gpu_req = 1'b0;
    repeat (3) @(negedge clock);

    // CPU request arriving under continuous GPU pressure
    gpu_req = 1'b1; gpu_a = 12'h300; ga_exp = 12'h300; t_rdy = -1; t_ack = -1;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h010; end
      @(negedge clock);
      if (gpu_ack) begin
        chk("starve_gpu_q", gpu_q, fill(ga_exp));
        ga_exp = ga_exp + 12'd1;
        gpu_a = gpu_a + 12'd1;
        if (t_rdy >= 0 && t_ack < 0) t_ack = k;
      end
      if (cpu_ready) begin
        chk("starve_cpu_q", cpu_q, 8'h33);
        if (t_rdy < 0) t_rdy = k;
        cpu_req = 1'b0;
      end
    end
    gpu_req = 1'b0;
    chk("starve_ready_seen", (t_rdy >= 0), 1'b1);
    chk("starve_latency_bound", (t_rdy >= 4 && (t_rdy - 4) <= 8), 1'b1);
    chk("starve_gpu_resumes", (t_ack > t_rdy && (t_ack - t_rdy) <= 3), 1'b1);

    // random traffic against the reference model
    @(negedge clock);
    reset_n = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0;
    init_req = 1'b1;
    @(negedge clock);
    init_req = 1'b0;
    reset_n = 1'b1;
    model_reset();
    cpu_pend = 1'b0; gpu_pend = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (m_who == 2 && m_ph == 2) cpu_pend = 1'b0;
      if (m_who == 1 && m_ph == 2) gpu_pend = 1'b0;
      if (!cpu_pend && $urandom_range(0, 2) == 0) begin
        cpu_pend = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_a = 12'h100 + 12'($urandom_range(0, 15));
        cpu_d = 8'($urandom);
      end
      if (!gpu_pend && $urandom_range(0, 1) == 0) begin
        gpu_pend = 1'b1;
        gpu_a = 12'h100 + 12'($urandom_range(0, 15));
      end
      cpu_req = cpu_pend; gpu_req = gpu_pend;
      model_step();
      @(negedge clock);
      chk($sformatf("rnd%0d_ready", k), cpu_ready, (m_who == 2 && m_ph == 2));
      chk($sformatf("rnd%0d_ack", k), gpu_ack, (m_who == 1 && m_ph == 2));
      chk($sformatf("rnd%0d_mem_w", k), mem_w, (m_who == 2 && m_ph == 1 && m_cwe));
      chk($sformatf("rnd%0d_mem_a", k), mem_a, e_ma);
      if (m_who == 2 && m_ph == 1 && m_cwe) chk($sformatf("rnd%0d_mem_d", k), mem_d, e_md);
      chk($sformatf("rnd%0d_cpu_q", k), cpu_q, e_cq);
      chk($sformatf("rnd%0d_gpu_q", k), gpu_q, e_gq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
